// File: rtl/addertree9_seq_ctrl.sv
// addertree9_seq_ctrl: sequencer for the 9-input fp16 adder tree.
// Feeds one 3x3 window beat per channel into the external tree, tracks the
// tree latency with a valid shift register, and folds the per-channel tree
// sums into a single fp16 accumulator in channel order.

// Combinational fp16 adder with round-to-nearest-even, subnormals, inf/NaN.
module float_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);
  logic        w_swap, w_sub, w_a_spec, w_b_spec, w_a_nan, w_b_nan, w_rnd;
  logic [15:0] w_big, w_sml;
  logic [4:0]  w_eb, w_es, w_d;
  logic [13:0] w_mb, w_ms, w_ms_sh, w_pre, w_norm;
  logic [31:0] w_tmp;
  logic [14:0] w_sum, w_packed, w_rounded;
  logic [5:0]  w_e;
  logic [3:0]  w_lz, w_sh;

  // Align, add/subtract, normalise and round; specials override at the end.
  always_comb begin
    w_swap  = i_b[14:0] > i_a[14:0];
    w_big   = w_swap ? i_b : i_a;
    w_sml   = w_swap ? i_a : i_b;
    w_sub   = w_big[15] ^ w_sml[15];
    // Subnormals share the scale of exponent 1, without the hidden bit.
    w_eb    = (w_big[14:10] == 5'd0) ? 5'd1 : w_big[14:10];
    w_es    = (w_sml[14:10] == 5'd0) ? 5'd1 : w_sml[14:10];
    w_mb    = {(w_big[14:10] != 5'd0), w_big[9:0], 3'b000};
    w_ms    = {(w_sml[14:10] != 5'd0), w_sml[9:0], 3'b000};
    w_d     = w_eb - w_es;
    w_tmp   = {w_ms, 18'd0} >> w_d;
    // Bits shifted past the guard positions collapse into a sticky lsb.
    w_ms_sh = {w_tmp[31:19], w_tmp[18] | (|w_tmp[17:0])};
    w_sum   = w_sub ? ({1'b0, w_mb} - {1'b0, w_ms_sh}) : ({1'b0, w_mb} + {1'b0, w_ms_sh});
    w_e     = {1'b0, w_eb};
    if (w_sum[14]) begin
      w_pre = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_e   = w_e + 6'd1;
    end else begin
      w_pre = w_sum[13:0];
    end
    w_lz = 4'd14;
    for (int k = 0; k < 14; k++) begin
      if (w_pre[k]) w_lz = 4'(13 - k);
    end
    // Never normalise below exponent 1: the remainder becomes a subnormal.
    w_sh      = (6'(w_lz) < (w_e - 6'd1)) ? w_lz : 4'(w_e - 6'd1);
    w_norm    = w_pre << w_sh;
    w_e       = w_e - 6'(w_sh);
    w_packed  = {(w_norm[13] ? w_e[4:0] : 5'd0), w_norm[12:3]};
    w_rnd     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    // A rounding carry ripples into the exponent field, up to infinity.
    w_rounded = w_packed + 15'(w_rnd);
    o_sum     = {w_big[15], w_rounded};
    if (w_e >= 6'd31) o_sum = {w_big[15], 15'h7C00};
    if (w_sum == 15'd0) o_sum = {i_a[15] & i_b[15], 15'd0};
    w_a_spec = (i_a[14:10] == 5'h1F);
    w_b_spec = (i_b[14:10] == 5'h1F);
    w_a_nan  = w_a_spec && (i_a[9:0] != 10'd0);
    w_b_nan  = w_b_spec && (i_b[9:0] != 10'd0);
    if (w_a_spec || w_b_spec) begin
      if (w_a_nan || w_b_nan || (w_a_spec && w_b_spec && (i_a[15] != i_b[15])))
        o_sum = 16'h7E00;
      else
        o_sum = w_a_spec ? i_a : i_b;
    end
  end
endmodule

module addertree9_seq_ctrl #(
  parameter int TREE_LAT = 1,
  parameter int CH_MAX   = 64,
  parameter int CNT_W    = $clog2(CH_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] ch_num,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0][15:0] in_data,
  output logic [8:0][15:0] tree_a,
  input  logic [15:0]      tree_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_ch_num, r_issued, r_accum;
  logic [TREE_LAT-1:0] r_vld_sr;
  logic [TREE_LAT:0]   w_vld_ext;
  logic [15:0]         r_acc, w_adder_sum;
  logic                r_done;
  logic                w_start_ok, w_fire, w_acc_en, w_last_fire, w_last_acc;

  float_adder u_acc_add (
    .i_a   (r_acc),
    .i_b   (tree_dout),
    .o_sum (w_adder_sum)
  );

  assign w_start_ok  = start && (ch_num != '0) && (ch_num <= CNT_W'(CH_MAX));
  assign in_ready    = (r_state == S_RUN) && (r_issued < r_ch_num);
  assign w_fire      = in_valid && in_ready;
  assign tree_a      = w_fire ? in_data : '0;
  // The oldest slot of the shift register marks a tree result arriving now.
  assign w_acc_en    = r_vld_sr[TREE_LAT-1];
  assign w_vld_ext   = {r_vld_sr, w_fire};
  assign w_last_fire = w_fire && (r_issued == r_ch_num - CNT_W'(1));
  assign w_last_acc  = w_acc_en && (r_accum == r_ch_num - CNT_W'(1));
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = (r_state == S_OUT);
  assign out_data    = r_acc;
  assign done        = r_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; the final accumulation wins over any other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_RUN;
      S_RUN: begin
        if (w_last_acc)       w_state_next = S_OUT;
        else if (w_last_fire) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (w_last_acc) w_state_next = S_OUT;
      S_OUT:   if (out_ready)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters, latency tracking, accumulator and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_num <= '0;
      r_issued <= '0;
      r_accum  <= '0;
      r_vld_sr <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_vld_sr <= w_vld_ext[TREE_LAT-1:0];
      r_done   <= (r_state == S_OUT) && out_ready;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_ch_num <= ch_num;
        r_issued <= '0;
        r_accum  <= '0;
      end else begin
        if (w_fire) r_issued <= r_issued + CNT_W'(1);
        if (w_acc_en) begin
          // First result is loaded as-is so a -0 channel sum survives.
          r_acc   <= (r_accum == '0) ? tree_dout : w_adder_sum;
          r_accum <= r_accum + CNT_W'(1);
        end
      end
    end
  end
endmodule
